// File: rtl/drop_scheduler_pkg.sv
// Shared Tetris timing package: scheduler state encoding, default timing constants
// and the level-to-gravity-period helper.
package tetris_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LOCK  = 2'd3
  } sched_state_t;

  localparam int unsigned BASE_TICKS = 25000000;
  localparam int unsigned LEVEL_STEP = 2000000;
  localparam int unsigned MIN_TICKS  = 2500000;
  localparam int unsigned SOFT_SHIFT = 3;
  localparam int unsigned LOCK_TICKS = 12500000;
  localparam int unsigned CNT_WIDTH  = 28;

  // A decrement that would drive the period below zero or under the floor saturates to the floor.
  function automatic logic [31:0] gravityPeriod(input logic [3:0]  lvl,
                                                input logic [31:0] baseTicks,
                                                input logic [31:0] levelStep,
                                                input logic [31:0] floorTicks);
    logic [31:0] dec;
    dec = 32'(lvl) * levelStep;
    if (dec >= baseTicks)
      return floorTicks;
    else if ((baseTicks - dec) < floorTicks)
      return floorTicks;
    else
      return baseTicks - dec;
  endfunction

endpackage

// File: rtl/drop_scheduler_if.sv
// Control/board-facing signal bundle of the drop scheduler; master is the game side,
// slave is the scheduler itself.
interface drop_scheduler_if;
  logic       start;
  logic       pause;
  logic [3:0] level;
  logic       soft_drop;
  logic       landed;
  logic       lock_ack;
  logic       game_over;
  logic       drop_tick;
  logic       lock_req;
  logic       running;
  logic [1:0] state;

  modport master (
    output start, pause, level, soft_drop, landed, lock_ack, game_over,
    input  drop_tick, lock_req, running, state
  );

  modport slave (
    input  start, pause, level, soft_drop, landed, lock_ack, game_over,
    output drop_tick, lock_req, running, state
  );
endinterface

// File: rtl/drop_scheduler_tick_counter.sv
// Count-to-N enable generator: clear wins over hold, and the counter wraps to zero
// on the edge where its terminal-count output is high.
module tick_counter #(
  parameter int unsigned WIDTH = 28
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_hold,
  input  logic [31:0] i_limit,
  output logic        o_terminal
);

  logic [WIDTH-1:0] r_count;

  // Using >= lets a limit that shrinks below the current count expire on the very next edge.
  assign o_terminal = (32'(r_count) >= (i_limit - 32'd1));

  always_ff @(posedge clock) begin
    if (reset || i_clear)
      r_count <= '0;
    else if (!i_hold)
      r_count <= o_terminal ? '0 : r_count + 1'b1;
  end

endmodule

// File: rtl/drop_scheduler.sv
// Gravity and lock sequencer emitting single-cycle drop ticks and the lock handshake.
// Define LOCK_DELAY_EN to add the LOCK_TICKS lock-delay window with landed-release cancel.
module drop_scheduler #(
  parameter int unsigned BASE_TICKS = tetris_pkg::BASE_TICKS,
  parameter int unsigned LEVEL_STEP = tetris_pkg::LEVEL_STEP,
  parameter int unsigned MIN_TICKS  = tetris_pkg::MIN_TICKS,
  parameter int unsigned SOFT_SHIFT = tetris_pkg::SOFT_SHIFT,
  parameter int unsigned LOCK_TICKS = tetris_pkg::LOCK_TICKS
) (
  input logic              clock,
  input logic              reset,
  drop_scheduler_if.slave  bus
);

  import tetris_pkg::*;

  sched_state_t r_state;
  sched_state_t r_savedState;
  logic         r_dropTick;
  logic         r_lockReq;
  logic         r_running;

  sched_state_t w_effState;
  logic [31:0]  w_period;
  logic [31:0]  w_softPeriod;
  logic [31:0]  w_effPeriod;
  logic         w_dropClear;
  logic         w_dropHold;
  logic         w_dropTerm;
  logic         w_lockExit;

  always_comb begin
    w_period     = gravityPeriod(bus.level, 32'(BASE_TICKS), 32'(LEVEL_STEP), 32'(MIN_TICKS));
    w_softPeriod = w_period >> SOFT_SHIFT;
    if (w_softPeriod == 32'd0)
      w_softPeriod = 32'd1;
    w_effPeriod  = bus.soft_drop ? w_softPeriod : w_period;
  end

  // While paused with pause already low, the edge acts as the saved state would.
  assign w_effState = (r_state == PAUSE) ? r_savedState : r_state;

`ifdef LOCK_DELAY_EN
  assign w_lockExit = (bus.lock_ack && r_lockReq) || (!bus.landed && !r_lockReq);
`else
  assign w_lockExit = bus.lock_ack && r_lockReq;
`endif

  always_comb begin
    w_dropClear = 1'b0;
    w_dropHold  = 1'b0;
    if (bus.game_over || r_state == IDLE)
      w_dropClear = 1'b1;
    else if (bus.pause)
      w_dropHold = 1'b1;
    else if (w_effState == LOCK) begin
      if (w_lockExit)
        w_dropClear = 1'b1;
      else
        w_dropHold = 1'b1;
    end
  end

  tick_counter #(.WIDTH(CNT_WIDTH)) u_dropCounter (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_dropClear),
    .i_hold     (w_dropHold),
    .i_limit    (w_effPeriod),
    .o_terminal (w_dropTerm)
  );

`ifdef LOCK_DELAY_EN
  logic w_lockClear;
  logic w_lockHold;
  logic w_lockTerm;

  // The lock counter only advances inside LOCK before lock_req rises.
  always_comb begin
    w_lockClear = 1'b0;
    w_lockHold  = 1'b0;
    if (bus.game_over || w_effState != LOCK)
      w_lockClear = 1'b1;
    else if (bus.pause || r_lockReq)
      w_lockHold = 1'b1;
    else if (w_lockExit)
      w_lockClear = 1'b1;
  end

  tick_counter #(.WIDTH(CNT_WIDTH)) u_lockCounter (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_lockClear),
    .i_hold     (w_lockHold),
    .i_limit    (32'(LOCK_TICKS)),
    .o_terminal (w_lockTerm)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_savedState <= IDLE;
      r_dropTick   <= 1'b0;
      r_lockReq    <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_dropTick <= 1'b0;
      if (bus.game_over) begin
        r_state      <= IDLE;
        r_savedState <= IDLE;
        r_lockReq    <= 1'b0;
        r_running    <= 1'b0;
      end else if (r_state == IDLE) begin
        if (bus.start) begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end
      end else if (bus.pause) begin
        if (r_state != PAUSE) begin
          r_savedState <= r_state;
          r_state      <= PAUSE;
          r_running    <= 1'b0;
        end
      end else begin
        r_state   <= w_effState;
        r_running <= 1'b1;
        case (w_effState)
          RUN: begin
            if (w_dropTerm) begin
              if (bus.landed) begin
                r_state <= LOCK;
`ifndef LOCK_DELAY_EN
                r_lockReq <= 1'b1;
`endif
              end else begin
                r_dropTick <= 1'b1;
              end
            end
          end
          LOCK: begin
            if (w_lockExit) begin
              r_state   <= RUN;
              r_lockReq <= 1'b0;
            end
`ifdef LOCK_DELAY_EN
            else if (w_lockTerm && !r_lockReq)
              r_lockReq <= 1'b1;
`endif
          end
          default: begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.drop_tick = r_dropTick;
  assign bus.lock_req  = r_lockReq;
  assign bus.running   = r_running;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed bench for drop_scheduler with short periods; the lock scenarios follow
// whichever LOCK_DELAY_EN build is being compiled.
module tb_drop_scheduler;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  drop_scheduler_if bus ();

  drop_scheduler #(
    .BASE_TICKS (100),
    .LEVEL_STEP (10),
    .MIN_TICKS  (20),
    .SOFT_SHIFT (2),
    .LOCK_TICKS (30)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Counts edges until drop_tick is seen high; returns limit on timeout.
  task automatic waitTick(input int limit, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (bus.drop_tick !== 1'b1 && n < limit);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.pause = 1'b0; bus.level = 4'd0; bus.soft_drop = 1'b0;
    bus.landed = 1'b0; bus.lock_ack = 1'b0; bus.game_over = 1'b0;
    step(2);
    checks++;
    if ({bus.drop_tick, bus.lock_req, bus.running, bus.state} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b want=00000", {bus.drop_tick, bus.lock_req, bus.running, bus.state});
    end
    reset = 1'b0;
    bus.pause = 1'b1;
    step(3);
    checks++;
    if ({bus.running, bus.state} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL pause_in_idle got=%b want=000", {bus.running, bus.state});
    end
    bus.pause = 1'b0;
  endtask

  task automatic test_gravity();
    int n;
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    checks++;
    if ({bus.running, bus.state} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL start_run got=%b want=101", {bus.running, bus.state});
    end
    waitTick(1000, n);
    checks++;
    if (n !== 100) begin errors++; $display("[TB] FAIL first_tick got=%0d want=100", n); end
    waitTick(1000, n);
    checks++;
    if (n !== 100) begin errors++; $display("[TB] FAIL period_level0 got=%0d want=100", n); end
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    waitTick(1000, n);
    checks++;
    if (n !== 99) begin errors++; $display("[TB] FAIL start_ignored got=%0d want=99", n); end
  endtask

  task automatic test_level();
    int n;
    bus.level = 4'd9;
    waitTick(1000, n);
    checks++;
    if (n !== 20) begin errors++; $display("[TB] FAIL level9 got=%0d want=20", n); end
    bus.level = 4'd15;
    waitTick(1000, n);
    checks++;
    if (n !== 20) begin errors++; $display("[TB] FAIL level15_floor got=%0d want=20", n); end
    bus.level = 4'd0;
    waitTick(1000, n);
    checks++;
    if (n !== 100) begin errors++; $display("[TB] FAIL level0_again got=%0d want=100", n); end
    step(50);
    bus.level = 4'd9;
    step(1);
    checks++;
    if (bus.drop_tick !== 1'b1) begin errors++; $display("[TB] FAIL level_shorten got=%b want=1", bus.drop_tick); end
    bus.level = 4'd0;
    waitTick(1000, n);
    checks++;
    if (n !== 100) begin errors++; $display("[TB] FAIL level_restore got=%0d want=100", n); end
  endtask

  task automatic test_soft_drop();
    int n;
    bus.soft_drop = 1'b1;
    waitTick(1000, n);
    checks++;
    if (n !== 25) begin errors++; $display("[TB] FAIL soft_level0 got=%0d want=25", n); end
    bus.level = 4'd9;
    waitTick(1000, n);
    checks++;
    if (n !== 5) begin errors++; $display("[TB] FAIL soft_level9 got=%0d want=5", n); end
    bus.level = 4'd0;
    bus.soft_drop = 1'b0;
    waitTick(1000, n);
    checks++;
    if (n !== 100) begin errors++; $display("[TB] FAIL soft_release got=%0d want=100", n); end
  endtask

  task automatic test_pause();
    int n;
    int ticks;
    step(40);
    bus.pause = 1'b1;
    step(1);
    checks++;
    if ({bus.running, bus.state} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL pause_enter got=%b want=010", {bus.running, bus.state});
    end
    ticks = 0;
    for (int i = 0; i < 499; i++) begin
      step(1);
      if (bus.drop_tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks !== 0 || bus.state !== 2'd2) begin
      errors++;
      $display("[TB] FAIL pause_hold ticks=%0d state=%0d want ticks=0 state=2", ticks, bus.state);
    end
    bus.pause = 1'b0;
    waitTick(1000, n);
    checks++;
    if (n !== 60) begin errors++; $display("[TB] FAIL pause_resume got=%0d want=60", n); end
    checks++;
    if ({bus.running, bus.state} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL pause_exit got=%b want=101", {bus.running, bus.state});
    end
  endtask

  task automatic test_lock();
    int n;
    int ticks;
    bit sawReq;
    bus.lock_ack = 1'b1; step(1); bus.lock_ack = 1'b0;
    checks++;
    if ({bus.lock_req, bus.state} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL ack_in_run got=%b want=001", {bus.lock_req, bus.state});
    end
    bus.landed = 1'b1;
    n = 0; ticks = 0;
    do begin
      step(1);
      n++;
      if (bus.drop_tick === 1'b1) ticks++;
    end while (bus.state !== 2'd3 && n < 300);
    checks++;
    if (n !== 99 || ticks !== 0) begin
      errors++;
      $display("[TB] FAIL lock_entry cycles=%0d ticks=%0d want cycles=99 ticks=0", n, ticks);
    end
`ifdef LOCK_DELAY_EN
    checks++;
    if (bus.lock_req !== 1'b0) begin errors++; $display("[TB] FAIL lock_req_at_entry got=%b want=0", bus.lock_req); end
    bus.lock_ack = 1'b1; step(1); bus.lock_ack = 1'b0;
    checks++;
    if ({bus.lock_req, bus.state} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL lock_ack_early got=%b want=011", {bus.lock_req, bus.state});
    end
    step(28);
    checks++;
    if (bus.lock_req !== 1'b0) begin errors++; $display("[TB] FAIL lock_delay_pending got=%b want=0", bus.lock_req); end
    step(1);
    checks++;
    if (bus.lock_req !== 1'b1) begin errors++; $display("[TB] FAIL lock_delay_expire got=%b want=1", bus.lock_req); end
`else
    checks++;
    if (bus.lock_req !== 1'b1) begin errors++; $display("[TB] FAIL lock_req_at_entry got=%b want=1", bus.lock_req); end
    bus.landed = 1'b0;
    step(10);
    checks++;
    if ({bus.lock_req, bus.state} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL lock_hold_unlanded got=%b want=111", {bus.lock_req, bus.state});
    end
`endif
    bus.landed = 1'b0;
    bus.lock_ack = 1'b1; step(1); bus.lock_ack = 1'b0;
    checks++;
    if ({bus.lock_req, bus.state} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL lock_ack_release got=%b want=001", {bus.lock_req, bus.state});
    end
    waitTick(1000, n);
    checks++;
    if (n !== 100) begin errors++; $display("[TB] FAIL tick_after_ack got=%0d want=100", n); end
`ifdef LOCK_DELAY_EN
    bus.landed = 1'b1;
    n = 0;
    do begin step(1); n++; end while (bus.state !== 2'd3 && n < 300);
    checks++;
    if (n !== 100) begin errors++; $display("[TB] FAIL lock_entry2 got=%0d want=100", n); end
    step(9);
    bus.landed = 1'b0;
    step(1);
    checks++;
    if ({bus.lock_req, bus.state} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL landed_cancel got=%b want=001", {bus.lock_req, bus.state});
    end
    n = 0; sawReq = 1'b0;
    do begin
      step(1);
      n++;
      if (bus.lock_req === 1'b1) sawReq = 1'b1;
    end while (bus.drop_tick !== 1'b1 && n < 300);
    checks++;
    if (n !== 100 || sawReq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cancel_resume cycles=%0d lock_req_seen=%b want cycles=100 lock_req_seen=0", n, sawReq);
    end
`endif
  endtask

  task automatic test_game_over();
    int n;
    int ticks;
    int want;
`ifdef LOCK_DELAY_EN
    want = 130;
`else
    want = 100;
`endif
    bus.landed = 1'b1;
    n = 0;
    do begin step(1); n++; end while (bus.lock_req !== 1'b1 && n < 400);
    checks++;
    if (n !== want) begin errors++; $display("[TB] FAIL lock_req_rise got=%0d want=%0d", n, want); end
    bus.game_over = 1'b1; step(1); bus.game_over = 1'b0;
    checks++;
    if ({bus.drop_tick, bus.lock_req, bus.running, bus.state} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL game_over_idle got=%b want=00000", {bus.drop_tick, bus.lock_req, bus.running, bus.state});
    end
    bus.landed = 1'b0;
    ticks = 0;
    for (int i = 0; i < 250; i++) begin
      step(1);
      if (bus.drop_tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks !== 0 || bus.state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL game_over_quiet ticks=%0d state=%0d want ticks=0 state=0", ticks, bus.state);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    step(70);
    reset = 1'b1;
    step(1);
    checks++;
    if ({bus.drop_tick, bus.lock_req, bus.running, bus.state} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid got=%b want=00000", {bus.drop_tick, bus.lock_req, bus.running, bus.state});
    end
    reset = 1'b0;
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    waitTick(1000, n);
    checks++;
    if (n !== 100) begin errors++; $display("[TB] FAIL restart_tick got=%0d want=100", n); end
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_level();
    test_soft_drop();
    test_pause();
    test_lock();
    test_game_over();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
